gray_counter: RTL and testbench



---
 rtl/gray_counter_if.sv | 24 ++
 rtl/gray_counter.sv | 62 ++++++
 tb/tb_gray_counter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_counter_if.sv
// Output-side bundle of the Gray-code generator: control inputs plus the
// valid/ready code channel toward the Gray-to-binary converter.
interface gray_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_bin;
   logic [WIDTH-1:0] g;
   logic             out_valid;
   logic             out_ready;
   logic             tc;

   modport master (
      input  en, up, load, load_bin, out_ready,
      output g, out_valid, tc
   );

   modport slave (
      output en, up, load, load_bin, out_ready,
      input  g, out_valid, tc
   );
endinterface

// File: rtl/gray_counter.sv
// Binary counter whose current value is emitted as a registered Gray code
// through a one-entry valid/ready stage; wraps or saturates at the ends.
module gray_counter #(
   parameter int WIDTH = 4,
   parameter bit WRAP  = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   gray_counter_if.master       bus
);

   logic [WIDTH-1:0] cnt_reg;
   logic [WIDTH-1:0] cnt_next;
   logic [WIDTH-1:0] g_reg;
   logic             valid_reg;
   logic             tc_reg;
   logic             at_max;
   logic             at_min;
   logic             free;
   logic             step;
   logic             accept;

   assign at_max = (cnt_reg == {WIDTH{1'b1}});
   assign at_min = (cnt_reg == '0);
   assign free   = !valid_reg || bus.out_ready;
   assign accept = valid_reg && bus.out_ready;
   assign step   = bus.en && !bus.load && free;

   // Successor only; the emitted code is always gray of the current count.
   always_comb begin
      cnt_next = cnt_reg;
      if (bus.up) begin
         if (WRAP || !at_max) cnt_next = cnt_reg + WIDTH'(1);
      end else begin
         if (WRAP || !at_min) cnt_next = cnt_reg - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg   <= '0;
         g_reg     <= '0;
         valid_reg <= 1'b0;
         tc_reg    <= 1'b0;
      end else if (bus.load) begin
         cnt_reg <= bus.load_bin;
         if (accept) valid_reg <= 1'b0;
      end else if (step) begin
         g_reg     <= cnt_reg ^ (cnt_reg >> 1);
         valid_reg <= 1'b1;
         tc_reg    <= (bus.up && at_max) || (!bus.up && at_min);
         cnt_reg   <= cnt_next;
      end else if (accept) begin
         valid_reg <= 1'b0;
      end
   end

   assign bus.g         = g_reg;
   assign bus.out_valid = valid_reg;
   assign bus.tc        = tc_reg;

endmodule

// File: tb/tb_gray_counter.sv
// Drives a wrapping and a saturating gray_counter with shared stimulus and
// checks both against an arithmetic reference model of the counting rules.
module tb_gray_counter;
   localparam int W    = 4;
   localparam int MAXV = (1 << W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0, up = 1'b1, load = 1'b0, out_ready = 1'b1;
   logic [W-1:0] load_bin = '0;

   int tests_run = 0;
   int tests_failed = 0;

   gray_counter_if #(.WIDTH(W)) ifw ();
   gray_counter_if #(.WIDTH(W)) ifs ();

   assign ifw.en = en;  assign ifw.up = up;  assign ifw.load = load;
   assign ifw.load_bin = load_bin;  assign ifw.out_ready = out_ready;
   assign ifs.en = en;  assign ifs.up = up;  assign ifs.load = load;
   assign ifs.load_bin = load_bin;  assign ifs.out_ready = out_ready;

   gray_counter #(.WIDTH(W), .WRAP(1'b1)) dut_wrap (.clk(clk), .rst(rst), .bus(ifw));
   gray_counter #(.WIDTH(W), .WRAP(1'b0)) dut_sat  (.clk(clk), .rst(rst), .bus(ifs));

   always #5 clk = ~clk;

   // Index 0 = wrapping instance, 1 = saturating instance.
   logic [W-1:0] dut_g [2];
   logic         dut_v [2];
   logic         dut_tc[2];
   assign dut_g[0] = ifw.g;  assign dut_v[0] = ifw.out_valid;  assign dut_tc[0] = ifw.tc;
   assign dut_g[1] = ifs.g;  assign dut_v[1] = ifs.out_valid;  assign dut_tc[1] = ifs.tc;

   int m_cnt[2], m_g[2];
   bit m_v[2], m_tc[2];

   function automatic int gray_of(int b);
      return b ^ (b >> 1);
   endfunction

   function automatic int succ(int c, bit dir_up, bit wrap);
      if (dir_up) return wrap ? (c + 1) % (MAXV + 1) : ((c == MAXV) ? c : c + 1);
      return wrap ? (c + MAXV) % (MAXV + 1) : ((c == 0) ? 0 : c - 1);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0; m_g[i] = 0; m_v[i] = 0; m_tc[i] = 0;
      end
   endtask

   // Apply one clock edge to the model with the currently driven inputs, then
   // advance the simulation to just after that edge.
   task automatic tick();
      for (int i = 0; i < 2; i++) begin
         bit taken = m_v[i] && out_ready;
         if (load) begin
            m_cnt[i] = int'(load_bin);
            if (taken) m_v[i] = 0;
         end else if (en && (!m_v[i] || out_ready)) begin
            m_g[i]   = gray_of(m_cnt[i]);
            m_v[i]   = 1;
            m_tc[i]  = (up && m_cnt[i] == MAXV) || (!up && m_cnt[i] == 0);
            m_cnt[i] = succ(m_cnt[i], up, (i == 0));
         end else if (taken) begin
            m_v[i] = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      #12;
      for (int i = 0; i < 2; i++) begin
         tests_run++;
         if (dut_g[i] !== '0 || dut_v[i] !== 1'b0 || dut_tc[i] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset[%0d]: got g=%h v=%b tc=%b, expected g=0 v=0 tc=0",
                     i, dut_g[i], dut_v[i], dut_tc[i]);
         end
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_up_wrap();
      int exp_g[17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
      logic [W-1:0] prev;
      en = 1; up = 1; out_ready = 1;
      for (int k = 0; k < 17; k++) begin
         tick();
         tests_run++;
         if (dut_g[0] !== W'(exp_g[k]) || dut_v[0] !== 1'b1 || dut_tc[0] !== (exp_g[k] == 8)) begin
            tests_failed++;
            $display("FAIL up_wrap step %0d: got g=%h v=%b tc=%b, expected g=%h v=1 tc=%b",
                     k, dut_g[0], dut_v[0], dut_tc[0], exp_g[k], exp_g[k] == 8);
         end
         if (k > 0) begin
            tests_run++;
            if ($countones(dut_g[0] ^ prev) != 1) begin
               tests_failed++;
               $display("FAIL up_wrap_onebit step %0d: got %h after %h, expected one-bit change",
                        k, dut_g[0], prev);
            end
         end
         prev = dut_g[0];
         tests_run++;
         if (dut_g[1] !== W'(m_g[1]) || dut_tc[1] !== m_tc[1]) begin
            tests_failed++;
            $display("FAIL up_sat step %0d: got g=%h tc=%b, expected g=%h tc=%b",
                     k, dut_g[1], dut_tc[1], m_g[1], m_tc[1]);
         end
      end
      en = 0;
   endtask

   task automatic test_down_load();
      int exp_g[5] = '{2, 3, 1, 0, 8};
      load = 1; load_bin = 4'd3; en = 0;
      tick();
      load = 0; up = 0; en = 1;
      for (int k = 0; k < 5; k++) begin
         tick();
         tests_run++;
         if (dut_g[0] !== W'(exp_g[k]) || dut_tc[0] !== (exp_g[k] == 0)) begin
            tests_failed++;
            $display("FAIL down_load step %0d: got g=%h tc=%b, expected g=%h tc=%b",
                     k, dut_g[0], dut_tc[0], exp_g[k], exp_g[k] == 0);
         end
      end
      en = 0; up = 1;
   endtask

   task automatic test_back_pressure();
      int exp_after[2] = '{3, 2};
      load = 1; load_bin = 4'd1; out_ready = 1;
      tick();
      load = 0; en = 1;
      tick();
      out_ready = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         tests_run++;
         if (dut_g[0] !== 4'h1 || dut_v[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL back_pressure hold %0d: got g=%h v=%b, expected g=1 v=1",
                     k, dut_g[0], dut_v[0]);
         end
      end
      out_ready = 1;
      for (int k = 0; k < 2; k++) begin
         tick();
         tests_run++;
         if (dut_g[0] !== W'(exp_after[k]) || dut_v[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL back_pressure resume %0d: got g=%h v=%b, expected g=%h v=1",
                     k, dut_g[0], dut_v[0], exp_after[k]);
         end
      end
      en = 0;
   endtask

   task automatic test_saturate();
      int exp_g[4]  = '{9, 8, 8, 8};
      bit exp_tc[4] = '{0, 1, 1, 1};
      load = 1; load_bin = 4'd14;
      tick();
      load = 0; up = 1; en = 1;
      for (int k = 0; k < 4; k++) begin
         tick();
         tests_run++;
         if (dut_g[1] !== W'(exp_g[k]) || dut_tc[1] !== exp_tc[k]) begin
            tests_failed++;
            $display("FAIL saturate step %0d: got g=%h tc=%b, expected g=%h tc=%b",
                     k, dut_g[1], dut_tc[1], exp_g[k], exp_tc[k]);
         end
         tests_run++;
         if (dut_g[0] !== W'(m_g[0]) || dut_tc[0] !== m_tc[0]) begin
            tests_failed++;
            $display("FAIL saturate_wrapdut step %0d: got g=%h tc=%b, expected g=%h tc=%b",
                     k, dut_g[0], dut_tc[0], m_g[0], m_tc[0]);
         end
      end
   endtask

   task automatic test_collision();
      en = 1; load = 1; load_bin = 4'd5; out_ready = 1;
      tick();
      tests_run++;
      if (dut_v[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL collision_no_emit: got out_valid=%b, expected 0", dut_v[0]);
      end
      load = 0;
      tick();
      tests_run++;
      if (dut_g[0] !== 4'h7 || dut_v[0] !== 1'b1) begin
         tests_failed++;
         $display("FAIL collision_next: got g=%h v=%b, expected g=7 v=1", dut_g[0], dut_v[0]);
      end
      en = 0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         en        = ($urandom_range(0, 3) != 0);
         up        = $urandom_range(0, 1) == 1;
         load      = ($urandom_range(0, 9) == 0);
         load_bin  = W'($urandom_range(0, MAXV));
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
         for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (dut_g[i] !== W'(m_g[i]) || dut_v[i] !== m_v[i] || dut_tc[i] !== m_tc[i]) begin
               tests_failed++;
               $display("FAIL random[%0d] cycle %0d: got g=%h v=%b tc=%b, expected g=%h v=%b tc=%b",
                        i, k, dut_g[i], dut_v[i], dut_tc[i], m_g[i], m_v[i], m_tc[i]);
            end
         end
      end
      en = 0; load = 0; up = 1; out_ready = 1;
      tick();
   endtask

   task automatic test_async_reset();
      load = 1; load_bin = 4'd4;
      tick();
      load = 0; en = 1; up = 1; out_ready = 0;
      tick();
      tests_run++;
      if (dut_g[0] !== 4'h6 || dut_v[0] !== 1'b1) begin
         tests_failed++;
         $display("FAIL async_setup: got g=%h v=%b, expected g=6 v=1", dut_g[0], dut_v[0]);
      end
      #2 rst = 1'b1;
      #1;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         tests_run++;
         if (dut_g[i] !== '0 || dut_v[i] !== 1'b0 || dut_tc[i] !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset[%0d]: got g=%h v=%b tc=%b, expected g=0 v=0 tc=0",
                     i, dut_g[i], dut_v[i], dut_tc[i]);
         end
      end
      en = 0;
      #1 rst = 1'b0;
      tick();
      en = 1; out_ready = 1;
      tick();
      for (int i = 0; i < 2; i++) begin
         tests_run++;
         if (dut_g[i] !== '0 || dut_v[i] !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_first_code[%0d]: got g=%h v=%b, expected g=0 v=1",
                     i, dut_g[i], dut_v[i]);
         end
      end
      en = 0;
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_down_load();
      test_back_pressure();
      test_saturate();
      test_collision();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
